// File: rtl/monopix_data_rx_core_pkg.sv
// Shared definitions for the MONOPIX hit-readout receiver: FSM states,
// output word field positions and fixed phase lengths.
package monopix_data_rx_core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FRZ   = 3'd1,
        ST_RD    = 3'd2,
        ST_GAP   = 3'd3,
        ST_SHIFT = 3'd4,
        ST_STORE = 3'd5,
        ST_CHECK = 3'd6,
        ST_UNFRZ = 3'd7
    } rx_state_t;

    // Output word layout: identifier on top, hit bits right-aligned, zero pad between.
    localparam int WORD_W    = 32;
    localparam int IDENT_MSB = 31;
    localparam int IDENT_LSB = 28;

    // Phase counter width; wide enough for any legal DATA_BITS / delay setting.
    localparam int CNT_W = 8;

    // Fixed phase lengths of the handshake.
    localparam int GAP_CYCLES     = 2;
    localparam int CHECK_CYCLES   = 3;
    localparam int HOLDOFF_CYCLES = 2;

    localparam logic [7:0] LOST_MAX = 8'hFF;

endpackage

// File: rtl/monopix_data_rx_core_fifo.sv
// Word FIFO with show-ahead head output and asynchronous active-low reset.
// A push while full is refused; full is judged before any same-cycle pop.
module monopix_data_rx_core_fifo
    import monopix_data_rx_core_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic             CLK,
    input  logic             RST_B,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             empty,
    output logic             full,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign head  = empty ? '0 : mem[rd_ptr_reg];

    // Storage array: written only on an accepted push, never reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally (power-of-2 depth); count has one extra bit so full != empty.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/monopix_data_rx_core.sv
// MONOPIX readout receiver: runs the FREEZE/READ handshake, shifts in the
// serial hit, packs it into a 32-bit word and buffers it in a local FIFO.
module monopix_data_rx_core
    import monopix_data_rx_core_pkg::*;
#(
    parameter int         DATA_BITS  = 26,
    parameter logic [3:0] IDENTIFIER = 4'b0010,
    parameter int         FIFO_DEPTH = 64,
    parameter int         FREEZE_DLY = 4,
    parameter int         READ_WIDTH = 2
) (
    input  logic        CLK,
    input  logic        RST_B,
    input  logic        ENABLE,
    input  logic        TOKEN,
    input  logic        DATA,
    output logic        FREEZE,
    output logic        READ,
    output logic        CLK_OUT_EN,
    input  logic        FIFO_READ,
    output logic        FIFO_EMPTY,
    output logic [31:0] FIFO_DATA,
    output logic [7:0]  LOST_CNT,
    output logic        BUSY
);

    logic                 tok_meta_reg;
    logic                 tok_s_reg;
    rx_state_t            state_reg;
    rx_state_t            state_next;
    logic [CNT_W-1:0]     cnt_reg;
    logic [CNT_W-1:0]     cnt_next;
    logic [DATA_BITS-1:0] sr_reg;
    logic [7:0]           lost_cnt_reg;
    logic [WORD_W-1:0]    store_word;
    logic                 push;
    logic                 fifo_full;

    // Two-flop synchroniser for the chip token.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            tok_meta_reg <= 1'b0;
            tok_s_reg    <= 1'b0;
        end else begin
            tok_meta_reg <= TOKEN;
            tok_s_reg    <= tok_meta_reg;
        end
    end

    // Next-state logic; cnt counts cycles spent in the current state.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CNT_W'(1);
        case (state_reg)
            ST_IDLE: begin
                // Saturating hold-off so the token is not re-sampled right after UNFRZ.
                if (cnt_reg < CNT_W'(HOLDOFF_CYCLES)) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end else begin
                    cnt_next = cnt_reg;
                    if (ENABLE && tok_s_reg) state_next = ST_FRZ;
                end
            end
            ST_FRZ:   if (cnt_reg == CNT_W'(FREEZE_DLY - 1)) state_next = ST_RD;
            ST_RD:    if (cnt_reg == CNT_W'(READ_WIDTH - 1)) state_next = ST_GAP;
            ST_GAP:   if (cnt_reg == CNT_W'(GAP_CYCLES - 1)) state_next = ST_SHIFT;
            ST_SHIFT: if (cnt_reg == CNT_W'(DATA_BITS - 1))  state_next = ST_STORE;
            ST_STORE: state_next = ST_CHECK;
            ST_CHECK: begin
                if (cnt_reg == CNT_W'(CHECK_CYCLES - 1)) begin
                    state_next = (tok_s_reg && ENABLE) ? ST_RD : ST_UNFRZ;
                end
            end
            ST_UNFRZ: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (state_next != state_reg) cnt_next = '0;
    end

    // State and phase counter registers; reset leaves IDLE immediately live.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= CNT_W'(HOLDOFF_CYCLES);
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Serial-in shift register, MSB arrives first.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            sr_reg <= '0;
        end else if (state_reg == ST_SHIFT) begin
            sr_reg <= DATA_BITS'({sr_reg, DATA});
        end
    end

    // Word packing: identifier on top, hit right-aligned, everything else zero.
    always_comb begin
        store_word                      = '0;
        store_word[DATA_BITS-1:0]       = sr_reg;
        store_word[IDENT_MSB:IDENT_LSB] = IDENTIFIER;
    end

    assign push       = (state_reg == ST_STORE);
    assign FREEZE     = (state_reg != ST_IDLE) && (state_reg != ST_UNFRZ);
    assign READ       = (state_reg == ST_RD);
    assign CLK_OUT_EN = (state_reg == ST_SHIFT);
    assign BUSY       = (state_reg != ST_IDLE);
    assign LOST_CNT   = lost_cnt_reg;

    // Saturating count of words refused by a full FIFO.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            lost_cnt_reg <= '0;
        end else if (push && fifo_full && (lost_cnt_reg != LOST_MAX)) begin
            lost_cnt_reg <= lost_cnt_reg + 8'd1;
        end
    end

    monopix_data_rx_core_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST_B     (RST_B),
        .push      (push),
        .push_data (store_word),
        .pop       (FIFO_READ),
        .empty     (FIFO_EMPTY),
        .full      (fifo_full),
        .head      (FIFO_DATA)
    );

endmodule

// File: tb/tb_monopix_data_rx_core.sv
// Self-checking bench for monopix_data_rx_core: a behavioural chip model serves
// queued hits over READ/DATA, and a queue-based FIFO model predicts words and drops.
`timescale 1ns/1ps
module tb_monopix_data_rx_core;

    localparam int DATA_BITS  = 26;
    localparam int FIFO_DEPTH = 4;
    localparam int FREEZE_DLY = 4;
    localparam int READ_WIDTH = 2;
    localparam int HIT_PERIOD = READ_WIDTH + 2 + DATA_BITS + 1 + 3;

    logic        CLK = 1'b0;
    logic        RST_B = 1'b1;
    logic        ENABLE = 1'b0;
    logic        TOKEN = 1'b0;
    logic        DATA = 1'b0;
    logic        FIFO_READ = 1'b0;
    logic        FREEZE, READ, CLK_OUT_EN, FIFO_EMPTY, BUSY;
    logic [31:0] FIFO_DATA;
    logic [7:0]  LOST_CNT;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Chip model state
    logic [25:0] chip_hits[$];
    logic [25:0] chip_cur = '0;
    int          chip_bit = -1;
    logic        read_q = 1'b0;

    // Reference model of the output FIFO
    logic [31:0] model_q[$];
    int          model_lost = 0;

    monopix_data_rx_core #(
        .DATA_BITS  (DATA_BITS),
        .IDENTIFIER (4'b0010),
        .FIFO_DEPTH (FIFO_DEPTH),
        .FREEZE_DLY (FREEZE_DLY),
        .READ_WIDTH (READ_WIDTH)
    ) dut (
        .CLK        (CLK),
        .RST_B      (RST_B),
        .ENABLE     (ENABLE),
        .TOKEN      (TOKEN),
        .DATA       (DATA),
        .FREEZE     (FREEZE),
        .READ       (READ),
        .CLK_OUT_EN (CLK_OUT_EN),
        .FIFO_READ  (FIFO_READ),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_DATA  (FIFO_DATA),
        .LOST_CNT   (LOST_CNT),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Chip: load a hit on each READ rise, shift it out MSB first while CLK_OUT_EN,
    // keep TOKEN high while unread hits remain.
    always @(negedge CLK) begin
        if (READ && !read_q && chip_hits.size() > 0) begin
            chip_cur = chip_hits.pop_front();
            chip_bit = DATA_BITS - 1;
        end
        if (CLK_OUT_EN && chip_bit >= 0) begin
            DATA = chip_cur[chip_bit];
            chip_bit--;
        end
        read_q = READ;
        TOKEN  = (chip_hits.size() > 0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic model_store(input logic [25:0] hit);
        logic [31:0] w;
        w = {4'b0010, 2'b00, 26'(hit)};
        if (model_q.size() < FIFO_DEPTH) model_q.push_back(w);
        else if (model_lost < 255) model_lost++;
    endtask

    task automatic pop_check(input string tag);
        chk({tag, "_empty"}, 32'(FIFO_EMPTY), 32'(model_q.size() == 0));
        if (model_q.size() > 0) begin
            chk({tag, "_data"}, FIFO_DATA, model_q[0]);
            $display("pop %s data=%h", tag, FIFO_DATA);
            FIFO_READ = 1'b1;
            step();
            FIFO_READ = 1'b0;
            void'(model_q.pop_front());
        end
    endtask

    task automatic drain(input string tag);
        while (model_q.size() > 0) pop_check(tag);
        chk({tag, "_final_empty"}, 32'(FIFO_EMPTY), 32'd1);
    endtask

    task automatic do_reset();
        RST_B = 1'b0;
        chip_hits.delete();
        model_q.delete();
        model_lost = 0;
        repeat (3) step();
        RST_B = 1'b1;
        step();
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (BUSY && t < 20000) begin step(); t++; end
        chk({tag, "_idle"}, 32'(BUSY), 32'd0);
    endtask

    task automatic run_frame(input string tag, output int n_reads, output int read_hi,
                             output int period, output int frz_low);
        int t;
        int last_rise;
        logic rp;
        n_reads = 0; read_hi = 0; period = 0; frz_low = 0; last_rise = -1; rp = 1'b0;
        t = 0;
        while (!BUSY && t < 100) begin step(); t++; end
        chk({tag, "_start"}, 32'(BUSY), 32'd1);
        t = 0;
        while (BUSY && t < 20000) begin
            if (READ && !rp) begin
                n_reads++;
                if (last_rise >= 0) period = cyc - last_rise;
                last_rise = cyc;
            end
            if (READ) read_hi++;
            if (n_reads > 0 && !FREEZE) frz_low++;
            rp = READ;
            step();
            t++;
        end
        chk({tag, "_end"}, 32'(BUSY), 32'd0);
        $display("frame %s reads=%0d lost=%0d", tag, n_reads, LOST_CNT);
    endtask

    task automatic hits_frame(input string tag, input int nh);
        logic [25:0] hv[$];
        int nr, rh, per, fl;
        for (int i = 0; i < nh; i++) begin
            hv.push_back(26'($urandom));
            chip_hits.push_back(hv[i]);
        end
        run_frame(tag, nr, rh, per, fl);
        chk({tag, "_reads"}, 32'(nr), 32'(nh));
        foreach (hv[i]) model_store(hv[i]);
    endtask

    initial begin
        int c0, c1, c2, t, w, nr, rh, per, fl, viol, np;
        logic [25:0] h0, hs;

        // ---- reset state ----
        #2 RST_B = 1'b0;
        repeat (2) step();
        chk("rst_freeze", 32'(FREEZE), 32'd0);
        chk("rst_read", 32'(READ), 32'd0);
        chk("rst_clk_out_en", 32'(CLK_OUT_EN), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_empty", 32'(FIFO_EMPTY), 32'd1);
        chk("rst_data", FIFO_DATA, 32'd0);
        chk("rst_lost", 32'(LOST_CNT), 32'd0);
        RST_B = 1'b1;
        step();

        // ---- single hit: latencies and packing ----
        ENABLE = 1'b1;
        chip_hits.push_back(26'h2AB_CDEF);
        t = 0;
        while (!TOKEN && t < 10) begin step(); t++; end
        chk("t1_token", 32'(TOKEN), 32'd1);
        c0 = cyc;
        t = 0;
        while (!FREEZE && t < 20) begin step(); t++; end
        c1 = cyc;
        chk("t1_freeze_lat", 32'(c1 - c0), 32'd3);
        t = 0;
        while (!READ && t < 20) begin step(); t++; end
        c2 = cyc;
        chk("t1_read_lat", 32'(c2 - c1), 32'(FREEZE_DLY));
        w = 0;
        while (READ && w < 20) begin w++; step(); end
        chk("t1_read_width", 32'(w), 32'(READ_WIDTH));
        wait_idle("t1");
        chk("t1_freeze_low", 32'(FREEZE), 32'd0);
        model_store(26'h2AB_CDEF);
        chk("t1_word", FIFO_DATA, 32'h22AB_CDEF);
        pop_check("t1");
        chk("t1_empty_after", 32'(FIFO_EMPTY), 32'd1);

        // ---- three hits in one frame ----
        chip_hits.push_back(26'h1);
        chip_hits.push_back(26'h3FF_FFFF);
        chip_hits.push_back(26'h0);
        run_frame("t2", nr, rh, per, fl);
        chk("t2_reads", 32'(nr), 32'd3);
        chk("t2_read_cycles", 32'(rh), 32'(3 * READ_WIDTH));
        chk("t2_period", 32'(per), 32'(HIT_PERIOD));
        chk("t2_freeze_low_cycles", 32'(fl), 32'd1);
        model_store(26'h1);
        model_store(26'h3FF_FFFF);
        model_store(26'h0);
        chk("t2_word0", FIFO_DATA, 32'h2000_0001);
        drain("t2");

        // ---- randomized frames and pops ----
        for (int it = 0; it < 8; it++) begin
            hits_frame("rnd", $urandom_range(1, 3));
            chk("rnd_lost", 32'(LOST_CNT), 32'(model_lost));
            np = $urandom_range(0, 3);
            for (int p = 0; p < np; p++) pop_check("rnd");
        end
        drain("rnd");

        // ---- overflow with a small FIFO ----
        do_reset();
        hits_frame("t3", 6);
        chk("t3_lost", 32'(LOST_CNT), 32'd2);
        chk("t3_nonempty", 32'(FIFO_EMPTY), 32'd0);
        drain("t3");

        // ---- ENABLE low blocks the handshake ----
        ENABLE = 1'b0;
        chip_hits.push_back(26'($urandom));
        viol = 0;
        repeat (20) begin
            step();
            if (FREEZE || READ || BUSY) viol++;
        end
        chk("t4_disabled_activity", 32'(viol), 32'd0);
        chip_hits.delete();
        repeat (4) step();

        // ---- ENABLE dropped during the first SHIFT of three hits ----
        ENABLE = 1'b1;
        h0 = 26'($urandom);
        chip_hits.push_back(h0);
        chip_hits.push_back(26'($urandom));
        chip_hits.push_back(26'($urandom));
        t = 0;
        while (!CLK_OUT_EN && t < 100) begin step(); t++; end
        chk("t4_shift_seen", 32'(CLK_OUT_EN), 32'd1);
        ENABLE = 1'b0;
        wait_idle("t4");
        chk("t4_freeze_low", 32'(FREEZE), 32'd0);
        model_store(h0);
        chip_hits.delete();
        pop_check("t4");
        chk("t4_one_word", 32'(FIFO_EMPTY), 32'd1);
        repeat (4) step();
        ENABLE = 1'b1;

        // ---- asynchronous reset in the middle of SHIFT ----
        hits_frame("t5a", 1);
        chip_hits.push_back(26'($urandom));
        t = 0;
        while (!CLK_OUT_EN && t < 100) begin step(); t++; end
        repeat (5) step();
        #2 RST_B = 1'b0;
        #1;
        chk("t5_async_freeze", 32'(FREEZE), 32'd0);
        chk("t5_async_read", 32'(READ), 32'd0);
        chk("t5_async_clk_out_en", 32'(CLK_OUT_EN), 32'd0);
        chk("t5_async_empty", 32'(FIFO_EMPTY), 32'd1);
        model_q.delete();
        model_lost = 0;
        chip_hits.delete();
        repeat (2) step();
        RST_B = 1'b1;
        step();
        chk("t5_empty", 32'(FIFO_EMPTY), 32'd1);
        chk("t5_lost", 32'(LOST_CNT), 32'd0);
        hits_frame("t5b", 1);
        drain("t5b");

        // ---- push and pop in the same cycle on a full FIFO ----
        hits_frame("t6_fill", FIFO_DEPTH);
        chk("t6_full_nonempty", 32'(FIFO_EMPTY), 32'd0);
        hs = 26'($urandom);
        chip_hits.push_back(hs);
        t = 0;
        while (!CLK_OUT_EN && t < 100) begin step(); t++; end
        t = 0;
        while (CLK_OUT_EN && t < 100) begin step(); t++; end
        chk("t6_head", FIFO_DATA, model_q[0]);
        FIFO_READ = 1'b1;
        step();
        FIFO_READ = 1'b0;
        wait_idle("t6");
        model_store(hs);          // full is judged before the pop: dropped
        void'(model_q.pop_front());
        chk("t6_lost_pushpop", 32'(LOST_CNT), 32'd1);
        drain("t6");

        // ---- saturation of the drop counter ----
        hits_frame("t6_sat", FIFO_DEPTH + 300);
        chk("t6_lost_sat", 32'(LOST_CNT), 32'd255);
        chk("t6_lost_model", 32'(LOST_CNT), 32'(model_lost));
        drain("t6_sat");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
